input_conditioner: RTL and testbench

Multi-channel conditioner for raw board inputs (buttons, switches). It synchronizes each asynchronous input to `clk`, debounces it, and produces one-cycle rising/falling edge strobes. It sits directly upstream of the SPI midpoint datapath, which takes the conditioned button as its clock-enable strobe and the conditioned switches as level controls.

---
 rtl/input_conditioner.sv | 53 +++++
 tb/tb_input_conditioner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Per-channel two-flop synchronizer, counter debouncer and registered
// rising/falling edge strobes for raw board inputs.
module input_conditioner #(
    parameter int CHANNELS  = 3,
    parameter int WAIT_TIME = 3,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIME - 1);

    logic [CHANNELS-1:0] sync0;
    logic [CHANNELS-1:0] sync1;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0        <= '0;
            sync1        <= '0;
            conditioned  <= '0;
            positiveedge <= '0;
            negativeedge <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0 <= noisysignal;
            sync1 <= sync0;
            for (int i = 0; i < CHANNELS; i++) begin
                positiveedge[i] <= 1'b0;
                negativeedge[i] <= 1'b0;
                // A bounce back to the current level restarts the window
                if (sync1[i] == conditioned[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    conditioned[i]  <= sync1[i];
                    positiveedge[i] <= sync1[i];
                    negativeedge[i] <= ~sync1[i];
                    cnt[i]          <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: latency, glitch rejection,
// bounce, asynchronous reset mid-count and channel independence.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] noisysignal;
    logic [2:0] conditioned;
    logic [2:0] positiveedge;
    logic [2:0] negativeedge;

    int n_vec = 0;
    int n_err = 0;

    input_conditioner #(
        .CHANNELS (3),
        .WAIT_TIME(3),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .noisysignal (noisysignal),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        noisysignal = 3'b000;
        reset = 1'b1;
        step();
        step();
        check("rst_cond", 32'(conditioned), 32'h0);
        check("rst_pos", 32'(positiveedge), 32'h0);
        check("rst_neg", 32'(negativeedge), 32'h0);
        reset = 1'b0;
    endtask

    logic [5:0] pat;
    int         npos;

    initial begin
        reset = 1'b1;
        noisysignal = 3'b000;
        do_reset();

        // clean rise on channel 0: visible at E4
        noisysignal = 3'b001;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rise_cond_E%0d", k), 32'(conditioned),
                  (k >= 4) ? 32'h1 : 32'h0);
            check($sformatf("rise_pos_E%0d", k), 32'(positiveedge),
                  (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("rise_neg_E%0d", k), 32'(negativeedge), 32'h0);
        end

        // clean fall
        noisysignal = 3'b000;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("fall_cond_E%0d", k), 32'(conditioned),
                  (k >= 4) ? 32'h0 : 32'h1);
            check($sformatf("fall_neg_E%0d", k), 32'(negativeedge),
                  (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("fall_pos_E%0d", k), 32'(positiveedge), 32'h0);
        end

        // 2-cycle glitch on channel 1
        noisysignal = 3'b010;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("glitch_cond_E%0d", k), 32'(conditioned), 32'h0);
            check($sformatf("glitch_pos_E%0d", k), 32'(positiveedge), 32'h0);
            check($sformatf("glitch_neg_E%0d", k), 32'(negativeedge), 32'h0);
            if (k == 1) noisysignal = 3'b000;
        end
        check("glitch_cnt1", 32'(dut.cnt[1]), 32'h0);

        // bounce 1,1,0,1,0,1 then steady 1: single strobe at E9
        pat  = 6'b101011;
        npos = 0;
        for (int k = 0; k < 12; k++) begin
            noisysignal = {2'b00, (k < 6) ? pat[k] : 1'b1};
            step();
            if (positiveedge[0]) npos++;
            check($sformatf("bounce_pos_E%0d", k), 32'(positiveedge[0]),
                  (k == 9) ? 32'h1 : 32'h0);
            check($sformatf("bounce_neg_E%0d", k), 32'(negativeedge), 32'h0);
        end
        check("bounce_npos", 32'(npos), 32'h1);
        check("bounce_cond", 32'(conditioned), 32'h1);

        // asynchronous reset while cnt=2
        do_reset();
        noisysignal = 3'b001;
        for (int k = 0; k < 4; k++) step();
        check("midcnt_cnt0", 32'(dut.cnt[0]), 32'h2);
        check("midcnt_cond", 32'(conditioned), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cond", 32'(conditioned), 32'h0);
        check("arst_pos", 32'(positiveedge), 32'h0);
        check("arst_cnt0", 32'(dut.cnt[0]), 32'h0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("postrst_pos_E%0d", k), 32'(positiveedge),
                  (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("postrst_cond_E%0d", k), 32'(conditioned),
                  (k >= 4) ? 32'h1 : 32'h0);
        end

        // channel 0 then channel 2 one cycle later
        do_reset();
        noisysignal = 3'b001;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 0) noisysignal = 3'b101;
            check($sformatf("indep_pos_E%0d", k), 32'(positiveedge),
                  (k == 4) ? 32'h1 : (k == 5) ? 32'h4 : 32'h0);
            check($sformatf("indep_ch1_E%0d", k), 32'(conditioned[1]), 32'h0);
        end
        check("indep_cond", 32'(conditioned), 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
